// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer between the memory stage and a
// 64-bit data memory (req/ack), with read-modify-write for narrow stores.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_CHECK_EN.
// Ports: clk, rst_n (async, active low)
//   core side : REQ WE SIZE ADDR WDATA -> BUSY DONE RDATA RSIZE ERR
//   mem side  : MEM_REQ MEM_WE MEM_ADDR MEM_WDATA <- MEM_RDATA MEM_ACK
// SIZE: 00 double, 01 word, 10 half, 11 byte. Little-endian lanes.

module mem_access_ctrl #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              REQ,
  input  logic              WE,
  input  logic [1:0]        SIZE,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [63:0]       WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [63:0]       RDATA,
  output logic [1:0]        RSIZE,
  output logic              ERR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [63:0]       MEM_WDATA,
  input  logic [63:0]       MEM_RDATA,
  input  logic              MEM_ACK
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state;

  // captured request
  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic [63:0] wdata_q;

  // registered outputs
  logic              busy_q;
  logic              done_q;
  logic [63:0]       rdata_q;
  logic [1:0]        rsize_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdata_q;

  function automatic logic [63:0] lane_mask(
    input logic [1:0] s
  );
    logic [63:0] m;
    m = '0;
    unique case (s)
      2'b00: m = {64{1'b1}};
      2'b01: m = 64'h0000_0000_ffff_ffff;
      2'b10: m = 64'h0000_0000_0000_ffff;
      2'b11: m = 64'h0000_0000_0000_00ff;
      default: m = '0;
    endcase
    return m;
  endfunction

  logic [2:0] cap_off;
  logic       mis;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic err_q;

  always_comb begin
    mis = 1'b0;
    unique case (SIZE)
      2'b00: mis = |ADDR[2:0];
      2'b01: mis = |ADDR[1:0];
      2'b10: mis = ADDR[0];
      2'b11: mis = 1'b0;
      default: mis = 1'b0;
    endcase
  end

  assign cap_off = ADDR[2:0];
  assign ERR     = err_q;
`else
  // Misaligned addresses are silently rounded down
  // to the lane boundary.
  always_comb begin
    cap_off = ADDR[2:0];
    unique case (SIZE)
      2'b00: cap_off = 3'b000;
      2'b01: cap_off = {ADDR[2], 2'b00};
      2'b10: cap_off = {ADDR[2:1], 1'b0};
      2'b11: cap_off = ADDR[2:0];
      default: cap_off = ADDR[2:0];
    endcase
  end

  assign mis = 1'b0;
  assign ERR = 1'b0;
`endif

  // lane datapath on the captured request
  logic [5:0]  sh;
  logic [63:0] mask;
  logic [63:0] load_lane;
  logic [63:0] merged;

  assign sh        = {off_q, 3'b000};
  assign mask      = lane_mask(size_q);
  assign load_lane = (MEM_RDATA >> sh) & mask;
  assign merged    = (MEM_RDATA & ~(mask << sh))
                   | ((wdata_q & mask) << sh);

  logic start_wr;
  assign start_wr = WE && (SIZE == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      off_q       <= '0;
      size_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= '0;
      rsize_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (REQ) begin
            off_q      <= cap_off;
            size_q     <= SIZE;
            we_q       <= WE;
            wdata_q    <= WDATA;
            rsize_q    <= SIZE;
            rdata_q    <= '0;
            busy_q     <= 1'b1;
            mem_addr_q <= {ADDR[ADDR_W-1:3], 3'b000};
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
            err_q      <= mis;
`endif
            if (mis) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else if (start_wr) begin
              state       <= S_WRITE;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= WDATA;
            end else begin
              state     <= S_READ;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (MEM_ACK) begin
            if (we_q) begin
              // request stays up; only the direction flips
              state       <= S_WRITE;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= merged;
            end else begin
              state     <= S_DONE;
              done_q    <= 1'b1;
              mem_req_q <= 1'b0;
              rdata_q   <= load_lane;
            end
          end
        end
        S_WRITE: begin
          if (MEM_ACK) begin
            state     <= S_DONE;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RDATA     = rdata_q;
  assign RSIZE     = rsize_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle data-memory access controller between the core's memory stage and a 64-bit data memory with a req/ack handshake. It accepts one load or store per request, with sizes byte, half, word or double. Sub-doubleword stores are done as read-modify-write. For loads it returns the addressed lane right-justified and zero-filled, together with its size code. Both outputs feed the downstream sign-extension mux (size code onto that mux's SELECT).

## Interface
Parameters:
- ADDR_W, 64, byte-address width of ADDR and MEM_ADDR

Ports (clock and reset are the single clock and the asynchronous active-low reset):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- REQ  in  1  access request; sampled only in IDLE
- WE  in  1  1 = store, 0 = load
- SIZE  in  2  00 double, 01 word, 10 half, 11 byte
- ADDR  in  ADDR_W  byte address
- WDATA  in  64  store data, right-justified
- BUSY  out  1  high in every state except IDLE (core stall)
- DONE  out  1  one-cycle completion pulse
- RDATA  out  64  load lane, right-justified, upper bits zero
- RSIZE  out  2  captured SIZE, goes to the extension mux SELECT
- ERR  out  1  misaligned access, valid with DONE
- MEM_REQ  out  1  memory request, held until MEM_ACK
- MEM_WE  out  1  memory write enable
- MEM_ADDR  out  ADDR_W  doubleword-aligned address, {ADDR[ADDR_W-1:3],3'b000}
- MEM_WDATA  out  64  full doubleword to write
- MEM_RDATA  in  64  read data, valid when MEM_ACK=1 and MEM_WE=0
- MEM_ACK  in  1  transfer complete; ignored when MEM_REQ=0

## Operation
- Request capture: in IDLE with REQ=1, the block registers ADDR, SIZE, WE and WDATA. Inputs are don't-care after capture.
- States: IDLE, READ, WRITE, DONE.
- From IDLE, on REQ, the next state is:
  - DONE with ERR=1 if the access is misaligned (see Configuration);
  - WRITE if it is a store with SIZE=00;
  - READ otherwise.
- READ: MEM_REQ=1, MEM_WE=0. On MEM_ACK the block captures MEM_RDATA.
  - Load: go to DONE.
  - Store: merge, then go to WRITE.
- WRITE: MEM_REQ=1, MEM_WE=1, MEM_WDATA = merged word (or WDATA when SIZE=00). On MEM_ACK, go to DONE.
- DONE: for one cycle DONE=1, then IDLE. RDATA, RSIZE and ERR hold until the next capture.
- Lane arithmetic (little-endian): off = ADDR[2:0], lane width n = 8/16/32/64 bits for SIZE 11/10/01/00.
  - Load: RDATA = (MEM_RDATA >> 8·off) & mask(n).
  - Store merge: replace bits [8·off+n-1 : 8·off] of the read word with WDATA[n-1:0]; all other bytes are preserved.
- Stores leave RDATA at 0.
- Reset (asynchronous, at any time, including mid-transaction) forces:
  - state IDLE;
  - all outputs 0 immediately; MEM_REQ drops without waiting for MEM_ACK;
  - the abandoned transaction is not resumed.

## Timing
- MEM_ACK may arrive in the first cycle of MEM_REQ or after any number of wait cycles. MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable until MEM_ACK.
- Latency with zero-wait memory, counted from the REQ sampling edge:
  - load: DONE in cycle +2;
  - double store: DONE in cycle +2;
  - sub-doubleword store: DONE in cycle +3;
  - misaligned access: DONE in cycle +1.
- Each memory wait cycle adds one cycle of latency.
- The earliest next capture is the cycle after DONE. REQ held high through DONE starts a new access in that IDLE cycle.
- MEM_REQ is deasserted in the cycle after MEM_ACK, unless a read moves straight into WRITE, in which case it stays high with MEM_WE rising.

## Configuration
- MEM_ACCESS_MISALIGN_CHECK_EN defined:
  - an access is misaligned when ADDR is not a multiple of its size (word needs ADDR[1:0]=0, half needs ADDR[0]=0, double needs ADDR[2:0]=0);
  - a misaligned access issues no memory transfer and produces DONE with ERR=1 and RDATA=0.
- Undefined:
  - ERR is tied to 0;
  - off is forced down to the size boundary (the low log2(n/8) bits are cleared) and the access proceeds normally.

## Test plan
Memory word at 0x100 holds 0x1122334455667788. Memory is zero-wait unless stated otherwise.
- Load byte, ADDR=0x103, SIZE=11 -> DONE in cycle +2, RDATA=0x0000000000000055, RSIZE=11, ERR=0, MEM_ADDR=0x100.
- Store half, ADDR=0x102, WDATA=0xABCD -> a read, then a write with MEM_WDATA=0x11223344ABCD7788; DONE in cycle +3.
- Store double, ADDR=0x100, WDATA=0xDEADBEEF00000001 -> a single write transfer with MEM_WE=1 only, no read cycle; the word becomes 0xDEADBEEF00000001.
- Load word, ADDR=0x102:
  - with the macro: DONE in cycle +1, ERR=1, MEM_REQ never asserted;
  - without it: RDATA=0x0000000055667788, ERR=0.
- Load double with MEM_ACK delayed 3 cycles -> MEM_REQ and BUSY high for 4 cycles, address stable throughout, DONE in cycle +5, RDATA=0x1122334455667788.
- rst_n pulled low during READ of a store -> MEM_REQ, BUSY and DONE are 0 immediately, memory is unchanged, and a REQ after release is accepted in the first active IDLE cycle.
